// File: rtl/pcm_player_pkg.sv
// Shared types and configuration limits for the PCM-to-PWM sample player.
package pcm_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  localparam int unsigned SAMPLE_W_MIN = 4;
  localparam int unsigned SAMPLE_W_MAX = 16;
  localparam int unsigned REP_MIN      = 1;
  localparam int unsigned REP_MAX      = 256;

  // Width of a counter running 0..rep-1, never narrower than one bit.
  function automatic int unsigned rep_width(input int unsigned rep);
    return (rep > 1) ? $clog2(rep) : 1;
  endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Free-running PWM carrier, carrier-period repeat counter, update tick and
// duty comparator; pwm is registered so it always equals (carrier < duty).
module pwm_carrier
  import pcm_player_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned REP      = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [SAMPLE_W-1:0] duty_nxt,
  output logic                tick_c,
  output logic                pwm
);

  localparam int unsigned         REP_W    = rep_width(REP);
  localparam logic [SAMPLE_W-1:0] CAR_MAX  = '1;
  localparam logic [REP_W-1:0]    REP_LAST = REP_W'(REP - 1);

  logic [SAMPLE_W-1:0] carrier;
  logic [SAMPLE_W-1:0] carrier_nxt;
  logic [REP_W-1:0]    rep_cnt;
  logic [REP_W-1:0]    rep_nxt;

  always_comb begin
    carrier_nxt = carrier + SAMPLE_W'(1);
    rep_nxt     = rep_cnt;
    if (carrier == CAR_MAX) begin
      rep_nxt = (rep_cnt == REP_LAST) ? '0 : rep_cnt + REP_W'(1);
    end
    tick_c = (carrier == CAR_MAX) && (rep_cnt == REP_LAST);
  end

  // Comparing next-state values keeps pwm aligned with the carrier it reflects.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carrier <= '0;
      rep_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      carrier <= carrier_nxt;
      rep_cnt <= rep_nxt;
      pwm     <= (carrier_nxt < duty_nxt);
    end
  end

endmodule

// File: rtl/pcm_pwm_player.sv
// Streams unsigned PCM samples from memory into a PWM output, one-shot or looped.
// Optional attenuation by vol is enabled with the macro PCM_PWM_PLAYER_VOLUME_EN.
module pcm_pwm_player
  import pcm_player_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REP      = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [2:0]          vol,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [SAMPLE_W-1:0] mem_data,
  output logic                pwm,
  output logic                busy,
  output logic                done
);

  state_e              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W-1:0]   start_q, start_n;
  logic [ADDR_W-1:0]   end_q, end_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [SAMPLE_W-1:0] next_sample, next_sample_n;
  logic [SAMPLE_W-1:0] duty, duty_n;
  logic [SAMPLE_W-1:0] load_val;
  logic                busy_n;
  logic                done_n;
  logic                mem_rd_n;
  logic                tick_c;

`ifdef PCM_PWM_PLAYER_VOLUME_EN
  assign load_val = next_sample >> vol;
`else
  logic unused_vol;
  assign unused_vol = ^vol;
  assign load_val   = next_sample;
`endif

  pwm_carrier #(
    .SAMPLE_W (SAMPLE_W),
    .REP      (REP)
  ) u_carrier (
    .clk      (clk),
    .rstn     (rstn),
    .duty_nxt (duty_n),
    .tick_c   (tick_c),
    .pwm      (pwm)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      start_q     <= '0;
      end_q       <= '0;
      next_sample <= '0;
      duty        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      start_q     <= start_n;
      end_q       <= end_n;
      next_sample <= next_sample_n;
      duty        <= duty_n;
      busy        <= busy_n;
      done        <= done_n;
      mem_rd      <= mem_rd_n;
      mem_addr    <= mem_addr_n;
    end
  end

  // Playback sequencing; the memory read strobe is raised for the cycle spent in FETCH.
  always_comb begin
    state_n       = state;
    addr_n        = addr;
    start_n       = start_q;
    end_n         = end_q;
    next_sample_n = next_sample;
    duty_n        = duty;
    busy_n        = busy;
    done_n        = 1'b0;
    mem_rd_n      = 1'b0;
    mem_addr_n    = mem_addr;

    case (state)
      ST_IDLE: begin
        if (start) begin
          start_n = start_addr;
          end_n   = end_addr;
          addr_n  = start_addr;
          busy_n  = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        next_sample_n = mem_data;
        state_n       = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick_c) begin
          duty_n = load_val;
          if (addr != end_q) begin
            addr_n  = addr + ADDR_W'(1);
            state_n = ST_FETCH;
          end else if (loop_en) begin
            addr_n  = start_q;
            state_n = ST_FETCH;
          end else begin
            state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (tick_c) begin
          duty_n  = '0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Abort silences the output at once and never reports completion.
    if (stop && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      duty_n  = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end

    if (state_n == ST_FETCH) begin
      mem_rd_n   = 1'b1;
      mem_addr_n = addr_n;
    end
  end

endmodule

// File: tb/tb_pcm_pwm_player.sv
// Scoreboard bench: expected PWM high-run lengths and read addresses are queued
// by the stimulus and popped by monitors as the players produce them.
module tb_pcm_pwm_player;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Player A: 4-bit samples, one carrier period per sample.
  logic        start_a, stop_a, loop_a;
  logic [31:0] saddr_a, eaddr_a, mem_addr_a;
  logic [2:0]  vol_a;
  logic        mem_rd_a, pwm_a, busy_a, done_a;
  logic [3:0]  mem_data_a;

  // Player B: 8-bit samples, two carrier periods per sample, attenuation input set.
  logic        start_b, stop_b, loop_b;
  logic [7:0]  saddr_b, eaddr_b, mem_addr_b;
  logic [2:0]  vol_b;
  logic        mem_rd_b, pwm_b, busy_b, done_b;
  logic [7:0]  mem_data_b;

  pcm_pwm_player #(.SAMPLE_W(4), .ADDR_W(32), .REP(1)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .stop(stop_a), .loop_en(loop_a),
    .start_addr(saddr_a), .end_addr(eaddr_a), .vol(vol_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
    .pwm(pwm_a), .busy(busy_a), .done(done_a)
  );

  pcm_pwm_player #(.SAMPLE_W(8), .ADDR_W(8), .REP(2)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .stop(stop_b), .loop_en(loop_b),
    .start_addr(saddr_b), .end_addr(eaddr_b), .vol(vol_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
    .pwm(pwm_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [3:0] mem_a_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 4'd4;
      32'h0000_0001: return 4'd8;
      32'h0000_0002: return 4'd15;
      32'h0000_0005: return 4'd3;
      32'h0000_0006: return 4'd10;
      32'hFFFF_FFFF: return 4'd9;
      default:       return 4'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd_a) mem_data_a <= mem_a_f(mem_addr_a);
    if (mem_rd_b) mem_data_b <= (mem_addr_b == 8'd0) ? 8'hF0 : 8'h00;
  end

  int vectors = 0;
  int errors  = 0;
  int          q_run_a[$];
  int          q_run_b[$];
  logic [31:0] q_addr_a[$];
  bit mon_run_a = 1'b1;
  int run_a = 0, run_b = 0;
  int rd_cnt_a = 0, done_cnt_a = 0, rd_target = 0;
  bit rd_prev_a = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: pop expectations on every completed high run and every read strobe.
  initial forever begin
    @(negedge clk);
    if (mon_run_a && pwm_a) run_a++;
    else if (mon_run_a && run_a != 0) begin
      if (q_run_a.size() == 0) check("run_a_extra", 32'(run_a), 32'd0);
      else check("run_a_len", 32'(run_a), 32'(q_run_a.pop_front()));
      run_a = 0;
    end else if (!mon_run_a) run_a = 0;

    if (pwm_b) run_b++;
    else if (run_b != 0) begin
      if (q_run_b.size() == 0) check("run_b_extra", 32'(run_b), 32'd0);
      else check("run_b_len", 32'(run_b), 32'(q_run_b.pop_front()));
      run_b = 0;
    end

    if (mem_rd_a) begin
      rd_cnt_a++;
      if (rd_prev_a) check("rd_a_one_cycle", 32'(rd_prev_a), 32'd0);
      if (q_addr_a.size() == 0) check("rd_a_extra", mem_addr_a, 32'hDEAD_BEEF);
      else check("rd_a_addr", mem_addr_a, q_addr_a.pop_front());
    end
    rd_prev_a = mem_rd_a;
    if (done_a) done_cnt_a++;
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return done_a;
      1:       return pwm_a;
      2:       return done_b;
      default: return rd_cnt_a >= rd_target;
    endcase
  endfunction

  task automatic wait_cond(input string nm, input int sel, input int budget);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(cond(sel)), 32'd1);
  endtask

  task automatic start_a_pulse(input logic [31:0] s, input logic [31:0] e, input logic lp);
    saddr_a = s; eaddr_a = e; loop_a = lp; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic drain_check(input string nm);
    repeat (6) @(negedge clk);
    check({nm, "_runs_left"}, 32'(q_run_a.size()), 32'd0);
    check({nm, "_addrs_left"}, 32'(q_addr_a.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, hi;
    rstn = 1'b0;
    start_a = 0; stop_a = 0; loop_a = 0; saddr_a = 0; eaddr_a = 0; vol_a = 3'd0;
    start_b = 0; stop_b = 0; loop_b = 0; saddr_b = 0; eaddr_b = 0; vol_b = 3'd4;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_mem_rd", 32'(mem_rd_a), 0);
    check("rst_mem_addr", mem_addr_a, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // One-shot 0..2: duties 4, 8, 15 of 16; a start while busy is ignored.
    q_addr_a = '{32'd0, 32'd1, 32'd2};
    q_run_a  = '{4, 8, 15};
    start_a_pulse(32'd0, 32'd2, 1'b0);
    check("busy_after_start", 32'(busy_a), 1);
    repeat (20) @(negedge clk);
    start_a_pulse(32'd5, 32'd6, 1'b0);
    wait_cond("oneshot_done", 0, 200);
    check("oneshot_busy_at_done", 32'(busy_a), 0);
    check("oneshot_pwm_at_done", 32'(pwm_a), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done_a), 0);
    drain_check("oneshot");

    // Loop 5..6, then clear loop_en during the second pass.
    q_addr_a = '{32'd5, 32'd6, 32'd5, 32'd6};
    q_run_a  = '{3, 10, 3, 10};
    rd_target = rd_cnt_a + 3;
    start_a_pulse(32'd5, 32'd6, 1'b1);
    wait_cond("loop_third_rd", 3, 200);
    loop_a = 1'b0;
    wait_cond("loop_done", 0, 200);
    check("loop_busy_at_done", 32'(busy_a), 0);
    drain_check("loop");

    // Stop while pwm is high.
    mon_run_a = 1'b0;
    q_addr_a = '{32'd0, 32'd1};
    d0 = done_cnt_a;
    start_a_pulse(32'd0, 32'd2, 1'b0);
    wait_cond("stop_pwm_high", 1, 100);
    repeat (2) @(negedge clk);
    check("stop_pwm_before", 32'(pwm_a), 1);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("stop_pwm_next", 32'(pwm_a), 0);
    check("stop_busy_next", 32'(busy_a), 0);
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (pwm_a) hi++;
    end
    check("stop_pwm_stays_low", 32'(hi), 0);
    check("stop_no_done", 32'(done_cnt_a - d0), 0);
    check("stop_addrs_left", 32'(q_addr_a.size()), 0);

    // Asynchronous reset mid-period.
    q_addr_a = '{32'd0, 32'd1};
    d0 = done_cnt_a;
    start_a_pulse(32'd0, 32'd2, 1'b0);
    wait_cond("rstmid_pwm_high", 1, 100);
    check("rstmid_addr_before", mem_addr_a, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_pwm", 32'(pwm_a), 0);
    check("rstmid_busy", 32'(busy_a), 0);
    check("rstmid_mem_rd", 32'(mem_rd_a), 0);
    check("rstmid_mem_addr", mem_addr_a, 0);
    check("rstmid_done", 32'(done_a), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt_a - d0), 0);
    check("rstmid_addrs_left", 32'(q_addr_a.size()), 0);
    mon_run_a = 1'b1;

    // Range crossing the top of the address space.
    q_addr_a = '{32'hFFFF_FFFF, 32'h0};
    q_run_a  = '{9, 4};
    start_a_pulse(32'hFFFF_FFFF, 32'h0, 1'b0);
    wait_cond("wrap_done", 0, 200);
    drain_check("wrap");

    // Single sample at the last address.
    q_addr_a = '{32'hFFFF_FFFF};
    q_run_a  = '{9};
    start_a_pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_cond("single_done", 0, 200);
    drain_check("single");

    // Attenuation: 0xF0 with vol=4, two carrier periods per sample.
`ifdef PCM_PWM_PLAYER_VOLUME_EN
    q_run_b = '{15, 15};
`else
    q_run_b = '{240, 240};
`endif
    saddr_b = 8'd0; eaddr_b = 8'd0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_cond("vol_done", 2, 2000);
    repeat (4) @(negedge clk);
    check("vol_runs_left", 32'(q_run_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
